sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port SRAM macro between the core's data (d) and instruction (i) OBI ports.
//  Performs range checking, arbitration with i-port starvation protection, and response routing.
//  Sits between the OBI mux outputs and the SRAM macro, replacing the dual-ported flop RAM.
// PARAMETERS
//  SRAM_BASE_ADDR  32'h8000_0000  base byte address of the SRAM window
//  SRAM_SIZE       4096           window size in bytes, power of two
//  ADDR_WIDTH      10             SRAM word-address width, log2(SRAM_SIZE/4)
//  STARVE_LIMIT    4              consecutive i-port conflict losses before the i-port is forced to win
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   synchronous active-high reset
//  sram_d_req_i      in   1   d-port OBI request
//  sram_d_gnt_o      out  1   d-port grant, combinational
//  sram_d_addr_i     in   32  d-port byte address
//  sram_d_we_i       in   1   d-port write enable
//  sram_d_be_i       in   4   d-port byte enables
//  sram_d_wdata_i    in   32  d-port write data
//  sram_d_rvalid_o   out  1   d-port response valid
//  sram_d_rdata_o    out  32  d-port read data
//  sram_i_*          -    -   same set and widths as sram_d_*; i-port is read-only
//  mem_req_o         out  1   SRAM access strobe
//  mem_we_o          out  1   SRAM write enable
//  mem_addr_o        out  ADDR_WIDTH  SRAM word address
//  mem_be_o          out  4   SRAM byte-write mask
//  mem_wdata_o       out  32  SRAM write data
//  mem_rdata_i       in   32  SRAM read data, valid the cycle after mem_req_o && !mem_we_o
//  illegal_memory_o  out  1   one-cycle pulse on a bad access
// BEHAVIOUR
//  - Reset: all registered outputs are 0, starve_cnt=0, resp_owner=NONE; no rvalid is issued for a request accepted in the reset cycle.
//  - At most one grant per cycle. The request and grant occur in the same cycle (A-phase). The response follows exactly 1 cycle later (R-phase). There is no back-pressure on R.
//  - Single requester: that requester is granted.
//  - Both requesting: the i-port is granted if starve_cnt >= STARVE_LIMIT, otherwise the d-port is granted. With STARVE_LIMIT=0, the i-port always wins.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) when the i-port loses a conflict; cleared on any i-port grant.
//  - Legal access (addr in [BASE, BASE+SIZE)): mem_* is driven combinationally from the winner, mem_addr_o=(addr-BASE)>>2, and addr[1:0] is ignored.
//  - Illegal access is granted but not forwarded (mem_req_o=0):
//    - out-of-range address, or any i-port write;
//    - the next cycle gives rvalid=1, rdata=32'hDEADBEEF for a read or 0 for a write, and illegal_memory_o=1.
//  - Writes also receive rvalid (OBI-compliant), with rdata=0.
//  - Response routing: registered resp_owner {NONE,D,I} plus resp_illegal and resp_we.
//    - rdata is mem_rdata_i for a legal read, otherwise the constant above.
//    - The rvalid of the non-owner is 0.
//  - Back-to-back: a new grant in the cycle that an R-phase completes is allowed, giving full throughput of 1 access/cycle.
//  - Address arithmetic is 32-bit unsigned. BASE+SIZE must not wrap past 2^32; an elaboration-time check enforces this.
// CONFIGURATION
//  SRAM_ARB_STATS_EN defined:
//    - adds outputs conflict_cnt_o[15:0] and forced_i_cnt_o[15:0];
//    - both counters saturate at 16'hFFFF and reset to 0 on rst_i;
//    - conflict_cnt_o counts cycles in which both ports request;
//    - forced_i_cnt_o counts i-port wins caused by starve_cnt.
//  SRAM_ARB_STATS_EN undefined: the ports and counters are absent; the rest of the behaviour is identical.
// STRUCTURE
//  sram_arb_pkg: typedef enum logic[1:0] {OWN_NONE,OWN_D,OWN_I} resp_owner_t; localparam DEADBEEF_WORD; obi_a_t struct {addr,we,be,wdata}.
//  Sub-module sram_arb_pick: combinational winner select plus the starve_cnt register; outputs grant_d, grant_i, forced.
//  Top level: range check, mem_* mux, R-phase registers, rdata/rvalid routing, illegal pulse, optional stats.
// TESTING
//  1. D read 0x8000_0010 alone, with mem_rdata_i=0x1234_5678 next cycle -> d_gnt=1, mem_addr_o=4, d_rvalid=1 with rdata 0x1234_5678 the cycle after; i_rvalid=0.
//  2. D and I both request reads continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; each rvalid lands on the correct port.
//  3. I read at 0x0000_0100 -> i_gnt=1, mem_req_o=0, next cycle i_rvalid=1, rdata=0xDEADBEEF, illegal_memory_o=1 for exactly one cycle.
//  4. I write to 0x8000_0000 -> mem_req_o=0, i_rvalid=1 with rdata=0, illegal_memory_o=1.
//  5. D write 0x8000_0FFC, be=4'b0101, wdata=0xAABBCCDD -> mem_we_o=1, mem_addr_o=0x3FF, mem_be_o=4'b0101; then a D read of 0x8000_1000 returns 0xDEADBEEF with an illegal pulse.
//  6. rst_i asserted in the grant cycle of a D read -> no d_rvalid the next cycle; starve_cnt=0; under SRAM_ARB_STATS_EN both counters read 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared types and constants for the SRAM port arbiter:
//     resp_owner_t  - which OBI port owns the pending R-phase response
//     DEADBEEF_WORD - read data returned for an illegal read
//     obi_a_t       - A-phase request fields of one OBI port
package sram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2
  } resp_owner_t;

  localparam logic [31:0] DEADBEEF_WORD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_a_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   One OBI port between the core-side OBI mux and the SRAM arbiter.
//   master : core side (drives req/addr/we/be/wdata, receives gnt/rvalid/rdata)
//   slave  : arbiter side
//   Signals: req, gnt, addr[31:0], we, be[3:0], wdata[31:0], rvalid, rdata[31:0]
interface sram_port_arbiter_if;
  import sram_arb_pkg::*;

  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/sram_arb_pick.sv
// sram_arb_pick
//   Combinational winner selection between the d- and i-port plus the
//   i-port starvation counter.
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     req_d_i, req_i_i  port requests
//     grant_d_o         d-port wins this cycle
//     grant_i_o         i-port wins this cycle
//     forced_o          i-port wins a conflict only because it was starved
module sram_arb_pick #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_d_i,
  input  logic req_i_i,
  output logic grant_d_o,
  output logic grant_i_o,
  output logic forced_o
);

  // At least one bit even when STARVE_LIMIT is 0 (i-port then always wins).
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             starved;
  logic             conflict;

  always_comb begin
    starved         = (starve_cnt_reg >= LIMIT);
    conflict        = req_d_i && req_i_i;
    grant_i_o       = req_i_i && (!req_d_i || starved);
    grant_d_o       = req_d_i && !grant_i_o;
    forced_o        = conflict && starved;
    starve_cnt_next = starve_cnt_reg;
    if (grant_i_o) begin
      starve_cnt_next = '0;
    end else if (conflict && !starved) begin
      // i-port lost; not starved means still below the saturation value
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM macro between the core's data (d) and
//   instruction (i) OBI ports: range check, arbitration with i-port
//   starvation protection, and one-cycle R-phase response routing.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     obi_d, obi_i        OBI ports (slave modport); i-port is read-only
//     mem_req_o/we_o/addr_o/be_o/wdata_o  SRAM macro A-phase (combinational)
//     mem_rdata_i         SRAM read data, valid the cycle after a read strobe
//     illegal_memory_o    one-cycle pulse in the R-phase of a bad access
//     conflict_cnt_o, forced_i_cnt_o  saturating statistics counters,
//                         present only when SRAM_ARB_STATS_EN is defined
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
  parameter int unsigned SRAM_SIZE      = 4096,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_port_arbiter_if.slave    obi_d,
  sram_port_arbiter_if.slave    obi_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  illegal_memory_o
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]           conflict_cnt_o,
  output logic [15:0]           forced_i_cnt_o
`endif
);

  // Elaboration-time sanity of the SRAM window.
  if ((64'(SRAM_BASE_ADDR) + 64'(SRAM_SIZE)) > 64'h1_0000_0000) begin : g_bad_window
    $error("sram_port_arbiter: SRAM_BASE_ADDR + SRAM_SIZE wraps past 2^32");
  end
  if (64'(SRAM_SIZE) != (64'd4 << ADDR_WIDTH)) begin : g_bad_size
    $error("sram_port_arbiter: SRAM_SIZE must equal 4 << ADDR_WIDTH");
  end

  // ---------------------------------------------------------------- A-phase
  logic   grant_d;
  logic   grant_i;
  logic   forced_i_win;
  logic   any_grant;
  obi_a_t d_a;
  obi_a_t i_a;
  obi_a_t win_a;
  logic [31:0] win_off;
  logic        in_range;
  logic        acc_illegal;

  sram_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_d_i   (obi_d.req),
    .req_i_i   (obi_i.req),
    .grant_d_o (grant_d),
    .grant_i_o (grant_i),
    .forced_o  (forced_i_win)
  );

  assign obi_d.gnt = grant_d;
  assign obi_i.gnt = grant_i;
  assign any_grant = grant_d | grant_i;

  assign d_a   = '{addr: obi_d.addr, we: obi_d.we, be: obi_d.be, wdata: obi_d.wdata};
  assign i_a   = '{addr: obi_i.addr, we: obi_i.we, be: obi_i.be, wdata: obi_i.wdata};
  assign win_a = grant_i ? i_a : d_a;

  // An address below the base wraps to a huge offset, so one unsigned
  // compare covers both ends of the window.
  assign win_off     = win_a.addr - SRAM_BASE_ADDR;
  assign in_range    = (win_off < 32'(SRAM_SIZE));
  assign acc_illegal = any_grant && (!in_range || (grant_i && i_a.we));

  assign mem_req_o   = any_grant && !acc_illegal;
  assign mem_we_o    = mem_req_o && win_a.we;
  assign mem_addr_o  = win_off[ADDR_WIDTH+1:2];
  assign mem_be_o    = win_a.be;
  assign mem_wdata_o = win_a.wdata;

  logic unused_off_bits;
  assign unused_off_bits = ^{win_off[31:ADDR_WIDTH+2], win_off[1:0]};

  // ---------------------------------------------------------------- R-phase
  resp_owner_t resp_owner_reg;
  resp_owner_t resp_owner_next;
  logic        resp_illegal_reg;
  logic        resp_illegal_next;
  logic        resp_we_reg;
  logic        resp_we_next;
  logic [31:0] resp_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_owner_reg   <= OWN_NONE;
      resp_illegal_reg <= 1'b0;
      resp_we_reg      <= 1'b0;
    end else begin
      resp_owner_reg   <= resp_owner_next;
      resp_illegal_reg <= resp_illegal_next;
      resp_we_reg      <= resp_we_next;
    end
  end

  // Every grant yields exactly one response next cycle; a new grant may be
  // taken while the previous response is being returned.
  always_comb begin
    resp_owner_next   = OWN_NONE;
    resp_illegal_next = 1'b0;
    resp_we_next      = 1'b0;
    if (grant_d) begin
      resp_owner_next = OWN_D;
    end else if (grant_i) begin
      resp_owner_next = OWN_I;
    end
    if (any_grant) begin
      resp_illegal_next = acc_illegal;
      resp_we_next      = win_a.we;
    end
  end

  always_comb begin
    resp_rdata = mem_rdata_i;
    if (resp_we_reg) begin
      resp_rdata = '0;
    end else if (resp_illegal_reg) begin
      resp_rdata = DEADBEEF_WORD;
    end
  end

  assign obi_d.rvalid = (resp_owner_reg == OWN_D);
  assign obi_i.rvalid = (resp_owner_reg == OWN_I);
  assign obi_d.rdata  = (resp_owner_reg == OWN_D) ? resp_rdata : '0;
  assign obi_i.rdata  = (resp_owner_reg == OWN_I) ? resp_rdata : '0;

  assign illegal_memory_o = resp_illegal_reg;

  // ---------------------------------------------------------------- stats
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] conflict_cnt_reg;
  logic [15:0] forced_i_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_reg <= '0;
      forced_i_cnt_reg <= '0;
    end else begin
      if (obi_d.req && obi_i.req && (conflict_cnt_reg != 16'hFFFF)) begin
        conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
      end
      if (forced_i_win && (forced_i_cnt_reg != 16'hFFFF)) begin
        forced_i_cnt_reg <= forced_i_cnt_reg + 16'd1;
      end
    end
  end

  assign conflict_cnt_o = conflict_cnt_reg;
  assign forced_i_cnt_o = forced_i_cnt_reg;
`else
  logic unused_forced;
  assign unused_forced = forced_i_win;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Table-driven bench: each row is one clock cycle of A-phase stimulus plus
//   the A-phase outputs expected in that cycle and the R-phase outputs
//   expected for the previous cycle's grant. Reset corner cases follow as
//   hand-written sequences. Optional statistics are checked when
//   SRAM_ARB_STATS_EN is defined.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        illegal_memory_o;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] conflict_cnt_o;
  logic [15:0] forced_i_cnt_o;
`endif

  sram_port_arbiter_if d_if ();
  sram_port_arbiter_if i_if ();

  sram_port_arbiter dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .obi_d            (d_if),
    .obi_i            (i_if),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_be_o         (mem_be_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rdata_i      (mem_rdata_i),
    .illegal_memory_o (illegal_memory_o)
`ifdef SRAM_ARB_STATS_EN
    ,
    .conflict_cnt_o   (conflict_cnt_o),
    .forced_i_cnt_o   (forced_i_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_we;
    logic [31:0] mem_rdata;
    logic        e_d_gnt;
    logic        e_i_gnt;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [9:0]  e_mem_addr;
    logic [3:0]  e_mem_be;
    logic [31:0] e_mem_wdata;
    logic        e_d_rv;
    logic        e_i_rv;
    logic [31:0] e_rdata;
    logic        e_ill;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic d_req, input logic [31:0] d_addr, input logic d_we,
    input logic [3:0] d_be, input logic [31:0] d_wdata,
    input logic i_req, input logic [31:0] i_addr, input logic i_we,
    input logic [31:0] mem_rdata,
    input logic e_d_gnt, input logic e_i_gnt, input logic e_mem_req,
    input logic e_mem_we, input logic [9:0] e_mem_addr, input logic [3:0] e_mem_be,
    input logic [31:0] e_mem_wdata,
    input logic e_d_rv, input logic e_i_rv, input logic [31:0] e_rdata, input logic e_ill);
    vec_t v;
    v.d_req = d_req;  v.d_addr = d_addr;  v.d_we = d_we;  v.d_be = d_be;
    v.d_wdata = d_wdata;  v.i_req = i_req;  v.i_addr = i_addr;  v.i_we = i_we;
    v.mem_rdata = mem_rdata;
    v.e_d_gnt = e_d_gnt;  v.e_i_gnt = e_i_gnt;  v.e_mem_req = e_mem_req;
    v.e_mem_we = e_mem_we;  v.e_mem_addr = e_mem_addr;  v.e_mem_be = e_mem_be;
    v.e_mem_wdata = e_mem_wdata;
    v.e_d_rv = e_d_rv;  v.e_i_rv = e_i_rv;  v.e_rdata = e_rdata;  v.e_ill = e_ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    d_if.req    = v.d_req;
    d_if.addr   = v.d_addr;
    d_if.we     = v.d_we;
    d_if.be     = v.d_be;
    d_if.wdata  = v.d_wdata;
    i_if.req    = v.i_req;
    i_if.addr   = v.i_addr;
    i_if.we     = v.i_we;
    i_if.be     = 4'hF;
    i_if.wdata  = 32'h1111_1111;
    mem_rdata_i = v.mem_rdata;
  endtask

  task automatic check_vec(input int n, input vec_t v);
    chk($sformatf("v%0d.d_gnt", n), 32'(d_if.gnt), 32'(v.e_d_gnt));
    chk($sformatf("v%0d.i_gnt", n), 32'(i_if.gnt), 32'(v.e_i_gnt));
    chk($sformatf("v%0d.mem_req", n), 32'(mem_req_o), 32'(v.e_mem_req));
    if (v.e_mem_req) begin
      chk($sformatf("v%0d.mem_we", n), 32'(mem_we_o), 32'(v.e_mem_we));
      chk($sformatf("v%0d.mem_addr", n), 32'(mem_addr_o), 32'(v.e_mem_addr));
      chk($sformatf("v%0d.mem_be", n), 32'(mem_be_o), 32'(v.e_mem_be));
      if (v.e_mem_we)
        chk($sformatf("v%0d.mem_wdata", n), mem_wdata_o, v.e_mem_wdata);
    end
    chk($sformatf("v%0d.d_rvalid", n), 32'(d_if.rvalid), 32'(v.e_d_rv));
    chk($sformatf("v%0d.i_rvalid", n), 32'(i_if.rvalid), 32'(v.e_i_rv));
    if (v.e_d_rv) chk($sformatf("v%0d.d_rdata", n), d_if.rdata, v.e_rdata);
    if (v.e_i_rv) chk($sformatf("v%0d.i_rdata", n), i_if.rdata, v.e_rdata);
    chk($sformatf("v%0d.illegal", n), 32'(illegal_memory_o), 32'(v.e_ill));
    $display("vec %0d d_gnt=%0b i_gnt=%0b mem_req=%0b mem_addr=%h d_rv=%0b i_rv=%0b rdata=%h ill=%0b",
             n, d_if.gnt, i_if.gnt, mem_req_o, mem_addr_o, d_if.rvalid, i_if.rvalid,
             d_if.rvalid ? d_if.rdata : i_if.rdata, illegal_memory_o);
  endtask

  localparam logic [31:0] DA = 32'h8000_0020; // d-port conflict address, word 8
  localparam logic [31:0] IA = 32'h8000_0040; // i-port conflict address, word 16

  initial begin
    vec_t idle_v;
    vec_t both_v;
    logic i_win;
    logic prev_i_win;

    // ---- table: single-port cases and legal/illegal responses
    // 0: idle, nothing pending from reset
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,            0,0,0,0,10'h000,4'h0,0, 0,0,0,0));
    // 1: D read 0x8000_0010 -> word 4
    vecs.push_back(mk(1,32'h8000_0010,0,4'hF,0, 0,0,0, 0, 1,0,1,0,10'h004,4'hF,0, 0,0,0,0));
    // 2: response with the macro's read data
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 32'h1234_5678, 0,0,0,0,0,0,0, 1,0,32'h1234_5678,0));
    // 3: I read out of range -> granted, not forwarded
    vecs.push_back(mk(0,0,0,0,0, 1,32'h0000_0100,0, 0, 0,1,0,0,0,0,0, 0,0,0,0));
    // 4: DEADBEEF response plus illegal pulse
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 32'h0BAD_0BAD, 0,0,0,0,0,0,0, 0,1,DEADBEEF_WORD,1));
    // 5: pulse is only one cycle wide
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 32'h0000_CAFE, 0,0,0,0,0,0,0, 0,0,0,0));
    // 6: I write in range -> illegal, not forwarded
    vecs.push_back(mk(0,0,0,0,0, 1,32'h8000_0000,1, 0, 0,1,0,0,0,0,0, 0,0,0,0));
    // 7: D write to the top word, back-to-back with the I write response
    vecs.push_back(mk(1,32'h8000_0FFC,1,4'b0101,32'hAABB_CCDD, 0,0,0, 32'h7777_7777,
                      1,0,1,1,10'h3FF,4'b0101,32'hAABB_CCDD, 0,1,0,1));
    // 8: D read just past the window; write response carries rdata 0
    vecs.push_back(mk(1,32'h8000_1000,0,4'hF,0, 0,0,0, 32'h7777_7777, 1,0,0,0,0,0,0, 1,0,0,0));
    // 9: illegal read response
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 32'h5555_5555, 0,0,0,0,0,0,0, 1,0,DEADBEEF_WORD,1));
    // 10..19: continuous conflict, pattern D,D,D,D,I repeating
    prev_i_win = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_win  = ((k % 5) == 4);
      both_v = mk(1,DA,0,4'hF,0, 1,IA,0, 32'hA000_0000 + 32'(10 + k),
                  !i_win, i_win, 1, 0, i_win ? 10'd16 : 10'd8, 4'hF, 0,
                  (k != 0) && !prev_i_win, (k != 0) && prev_i_win,
                  32'hA000_0000 + 32'(10 + k), 0);
      vecs.push_back(both_v);
      prev_i_win = i_win;
    end
    // 20: last response of the conflict run goes to the i-port
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 32'hA000_0014, 0,0,0,0,0,0,0, 0,1,32'hA000_0014,0));

    idle_v = vecs[0];

    // ---- reset
    rst_i = 1'b1;
    drive(idle_v);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    #4;
    chk("rst.d_rvalid", 32'(d_if.rvalid), 32'd0);
    chk("rst.i_rvalid", 32'(i_if.rvalid), 32'd0);
    chk("rst.illegal", 32'(illegal_memory_o), 32'd0);
    chk("rst.mem_req", 32'(mem_req_o), 32'd0);
`ifdef SRAM_ARB_STATS_EN
    chk("rst.conflict_cnt", 32'(conflict_cnt_o), 32'd0);
    chk("rst.forced_cnt", 32'(forced_i_cnt_o), 32'd0);
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // ---- table run
    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n]);
      #4;
      check_vec(n, vecs[n]);
      @(posedge clk_i); #1;
    end

`ifdef SRAM_ARB_STATS_EN
    chk("stats.conflict_cnt", 32'(conflict_cnt_o), 32'd10);
    chk("stats.forced_cnt", 32'(forced_i_cnt_o), 32'd2);
`endif

    // ---- reset during the grant cycle of a D read, after starve_cnt has grown
    both_v = vecs[10];
    for (int k = 0; k < 2; k++) begin
      drive(both_v);
      #4;
      chk($sformatf("pre_rst%0d.d_gnt", k), 32'(d_if.gnt), 32'd1);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    drive(vecs[1]);
    #4;
    $display("seq reset-in-grant d_gnt=%0b", d_if.gnt);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(idle_v);
    #4;
    chk("post_rst.d_rvalid", 32'(d_if.rvalid), 32'd0);
    chk("post_rst.i_rvalid", 32'(i_if.rvalid), 32'd0);
    chk("post_rst.illegal", 32'(illegal_memory_o), 32'd0);
`ifdef SRAM_ARB_STATS_EN
    chk("post_rst.conflict_cnt", 32'(conflict_cnt_o), 32'd0);
    chk("post_rst.forced_cnt", 32'(forced_i_cnt_o), 32'd0);
`endif
    $display("seq post-reset d_rv=%0b i_rv=%0b ill=%0b", d_if.rvalid, i_if.rvalid, illegal_memory_o);
    @(posedge clk_i); #1;
    // starve_cnt restarted from 0: four D wins before the i-port is forced
    for (int k = 0; k < 5; k++) begin
      drive(both_v);
      #4;
      chk($sformatf("post_rst_conf%0d.d_gnt", k), 32'(d_if.gnt), (k == 4) ? 32'd0 : 32'd1);
      chk($sformatf("post_rst_conf%0d.i_gnt", k), 32'(i_if.gnt), (k == 4) ? 32'd1 : 32'd0);
      $display("seq post-reset conflict %0d d_gnt=%0b i_gnt=%0b", k, d_if.gnt, i_if.gnt);
      @(posedge clk_i); #1;
    end
    drive(idle_v);
    @(posedge clk_i); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
